// File: rtl/go_pulse_gen.sv
// Step strobe generator: a rate divider in auto-run mode, or a debounced pushbutton in single-step mode.
// Also produces a heartbeat LED and a modulo-256 step counter for the debug displays.
module go_pulse_gen #(
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       mode,
    input  logic [1:0] rate_sel,
    input  logic       step_key_n,
    output logic       go,
    output logic       tick_led,
    output logic [7:0] step_count
);

    localparam int DEB_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DC_W       = $clog2(DEB_CYCLES);
    localparam int DIV_W      = $clog2(CLK_HZ);

    localparam logic [DC_W-1:0]  DC_TOP = DC_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] TOP_1HZ = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] TOP_2HZ = DIV_W'((CLK_HZ / 2) - 1);
    localparam logic [DIV_W-1:0] TOP_4HZ = DIV_W'((CLK_HZ / 4) - 1);
    localparam logic [DIV_W-1:0] TOP_8HZ = DIV_W'((CLK_HZ / 8) - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    logic             key_meta_r;
    logic             key_sync_r;
    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [DC_W-1:0]  dc_r;
    logic [DC_W-1:0]  dc_next_s;
    logic             press_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_next_s;
    logic [DIV_W-1:0] div_top_s;
    logic [1:0]       rate_prev_r;
    logic             wrap_s;
    logic             go_next_s;

    // Two-flop synchronizer; resets to the released level so a held key must re-qualify.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_r <= 1'b1;
            key_sync_r <= 1'b1;
        end else begin
            key_meta_r <= step_key_n;
            key_sync_r <= key_meta_r;
        end
    end

    // Debounce next-state: counter clears on every state change, press fires on qualification.
    always_comb begin
        state_next_s = state_r;
        dc_next_s    = {DC_W{1'b0}};
        press_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!key_sync_r) begin
                    state_next_s = ST_PRESS_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (key_sync_r) begin
                    state_next_s = ST_IDLE;
                end else if (dc_r == DC_TOP) begin
                    state_next_s = ST_HELD;
                    press_s      = 1'b1;
                end else begin
                    dc_next_s = dc_r + DC_W'(1);
                end
            end
            ST_HELD: begin
                if (key_sync_r) begin
                    state_next_s = ST_RELEASE_WAIT;
                end else begin
                    state_next_s = ST_HELD;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!key_sync_r) begin
                    state_next_s = ST_HELD;
                end else if (dc_r == DC_TOP) begin
                    state_next_s = ST_IDLE;
                end else begin
                    dc_next_s = dc_r + DC_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Debounce state and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            dc_r    <= {DC_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            dc_r    <= dc_next_s;
        end
    end

    // Terminal count of the divider for the selected auto rate.
    always_comb begin
        case (rate_sel)
            2'd0:    div_top_s = TOP_1HZ;
            2'd1:    div_top_s = TOP_2HZ;
            2'd2:    div_top_s = TOP_4HZ;
            2'd3:    div_top_s = TOP_8HZ;
            default: div_top_s = TOP_1HZ;
        endcase
    end

    // Divider next value; a rate change restarts the period without firing.
    always_comb begin
        div_next_s = {DIV_W{1'b0}};
        wrap_s     = 1'b0;
        if (!enable || mode) begin
            div_next_s = {DIV_W{1'b0}};
        end else if (rate_sel != rate_prev_r) begin
            div_next_s = {DIV_W{1'b0}};
        end else if (div_r == div_top_s) begin
            div_next_s = {DIV_W{1'b0}};
            wrap_s     = 1'b1;
        end else begin
            div_next_s = div_r + DIV_W'(1);
        end
    end

    // Divider and previous-rate registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_r       <= {DIV_W{1'b0}};
            rate_prev_r <= 2'd0;
        end else begin
            div_r       <= div_next_s;
            rate_prev_r <= rate_sel;
        end
    end

    // Only the source chosen by the current mode may fire; the other is dropped.
    always_comb begin
        go_next_s = enable & ((~mode & wrap_s) | (mode & press_s));
    end

    // Registered strobe with heartbeat toggle and step counter updated alongside it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            go         <= 1'b0;
            tick_led   <= 1'b0;
            step_count <= 8'd0;
        end else begin
            go <= go_next_s;
            if (go_next_s) begin
                tick_led   <= ~tick_led;
                step_count <= step_count + 8'd1;
            end else begin
                tick_led   <= tick_led;
                step_count <= step_count;
            end
        end
    end

endmodule

// File: tb/tb_go_pulse_gen.sv
// Scoreboard bench for go_pulse_gen: expected go cycles are queued when stimulus is driven
// and matched against the cycle on which the DUT raises go.
module tb_go_pulse_gen;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       mode;
    logic [1:0] rate_sel;
    logic       step_key_n;
    logic       go;
    logic       tick_led;
    logic [7:0] step_count;

    int         cyc;
    int         sb_q[$];
    int         n_checks;
    int         n_errors;
    int         exp_cnt;
    logic       exp_led;
    logic       prev_go;

    go_pulse_gen #(
        .CLK_HZ      (8000),
        .DEBOUNCE_MS (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .rate_sel   (rate_sel),
        .step_key_n (step_key_n),
        .go         (go),
        .tick_led   (tick_led),
        .step_count (step_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_go(input int t);
        sb_q.push_back(t);
        exp_cnt = (exp_cnt + 1) % 256;
        exp_led = ~exp_led;
    endtask

    // Press for 'hold' cycles, then release long enough for the debouncer to settle back to idle.
    task automatic press(input int hold, input bit expect_go);
        step_key_n = 1'b0;
        if (expect_go) push_go(cyc + 11);
        wait_cycles(hold);
        step_key_n = 1'b1;
        wait_cycles(14);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_count"}, {24'd0, step_count}, exp_cnt);
        check_eq({tag, "_led"}, {31'd0, tick_led}, {31'd0, exp_led});
        check_eq({tag, "_pending"}, sb_q.size(), 0);
    endtask

    // Each go must match the head of the scoreboard and never repeat on back-to-back cycles.
    initial prev_go = 1'b0;
    always @(negedge clock) begin
        if (reset_n && go) begin
            check_eq("go_back_to_back", {31'd0, prev_go}, 32'd0);
            if (sb_q.size() == 0) begin
                check_eq("go_unexpected_cycle", cyc, 0);
            end else begin
                check_eq("go_cycle", cyc, sb_q.pop_front());
            end
        end
        prev_go = go;
    end

    initial begin
        int c;
        n_checks   = 0;
        n_errors   = 0;
        exp_cnt    = 0;
        exp_led    = 1'b0;
        reset_n    = 1'b0;
        enable     = 1'b1;
        mode       = 1'b0;
        rate_sel   = 2'd0;
        step_key_n = 1'b1;
        wait_cycles(3);
        check_eq("reset_go", {31'd0, go}, 32'd0);
        check_outputs("reset");

        // Auto-run at 1 Hz: 8000-cycle period from reset release.
        reset_n = 1'b1;
        c = cyc;
        push_go(c + 8000);
        push_go(c + 16000);
        push_go(c + 24000);
        wait_cycles(24002);
        check_outputs("auto_1hz");

        // Rate change restarts the period from zero without firing.
        rate_sel = 2'd3;
        c = cyc;
        push_go(c + 1001);
        push_go(c + 2001);
        wait_cycles(2501);
        rate_sel = 2'd1;
        c = cyc;
        push_go(c + 4001);
        push_go(c + 8001);
        wait_cycles(8005);
        check_outputs("rate_change");

        // Single-step presses, glitch and bounce.
        mode = 1'b1;
        wait_cycles(2);
        press(50, 1'b1);
        press(50, 1'b1);
        check_outputs("clean_press");
        press(5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step_key_n = 1'b0;
            wait_cycles(3);
            step_key_n = 1'b1;
            wait_cycles(2);
        end
        press(50, 1'b1);
        check_outputs("bounce");

        // Disabled: neither source may fire, and the divider must stay parked at zero.
        enable = 1'b0;
        press(30, 1'b0);
        mode = 1'b0;
        wait_cycles(20000);
        check_outputs("gated");
        enable = 1'b1;
        c = cyc;
        push_go(c + 4000);
        wait_cycles(4003);
        mode = 1'b1;
        wait_cycles(2);
        check_outputs("reenable");

        // 256 presses from a fresh reset wrap the counter and the LED back to zero.
        reset_n = 1'b0;
        wait_cycles(2);
        exp_cnt = 0;
        exp_led = 1'b0;
        reset_n = 1'b1;
        wait_cycles(2);
        for (int i = 0; i < 256; i++) begin
            press(14, 1'b1);
            if (i == 254) check_eq("count_255", {24'd0, step_count}, 32'd255);
        end
        check_outputs("wrap");

        // Reset while held clears outputs asynchronously; the still-held key must re-qualify.
        step_key_n = 1'b0;
        push_go(cyc + 11);
        wait_cycles(14);
        reset_n = 1'b0;
        #1;
        exp_cnt = 0;
        exp_led = 1'b0;
        check_eq("async_go", {31'd0, go}, 32'd0);
        check_outputs("async_reset");
        wait_cycles(3);
        reset_n = 1'b1;
        push_go(cyc + 11);
        wait_cycles(30);
        step_key_n = 1'b1;
        wait_cycles(14);
        press(20, 1'b1);
        check_outputs("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
